switch_input_ctrl: RTL and testbench
====================================

Name: switch_input_ctrl

Overview:
Avalon-MM slave controller for the DE2 slide-switch bank. It sits between the raw `in_port` pins and the Nios II data master, in place of a bare input PIO. It performs:
- synchronisation of the raw inputs
- per-bit debounce on a shared prescaled tick
- both-edge change capture
- a maskable, level interrupt to the CPU

Software then sees clean switch state and one IRQ per debounced change.

Parameters:
- WIDTH, 18, number of switch inputs (1..32).
- DEBOUNCE_CYCLES, 50000, clk cycles per sample tick (1 ms at 50 MHz); must be >= 2.
- CNT_W, 16, prescaler width; 2**CNT_W must be >= DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  Avalon word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  raw, asynchronous switch levels.
- irq  out  1  level interrupt, active-high.

Behaviour:
- Reset (asynchronous): all state cleared.
  - readdata = 0, irq = 0.
  - sync flops = 0, prescaler = 0, primed = 0.
  - stable = 0, per-bit counters = 0.
  - mask = 0, edge = 0.
- Synchroniser: two flops per bit. sync[i] is in_port[i] delayed by 2 clk.
- Prescaler:
  - Counts 0..DEBOUNCE_CYCLES-1 and wraps to 0.
  - tick = 1 for exactly one cycle, when count == DEBOUNCE_CYCLES-1.
- Priming: on the first tick after reset, stable <= sync, all counters <= 0, primed <= 1, and no edge bits are set.
- Debounce (per bit, on tick, when primed):
  - If sync[i] == stable[i]: cnt[i] <= 0.
  - Else if cnt[i] == 2: stable[i] <= ~stable[i], cnt[i] <= 0, and chg[i] pulses for 1 cycle.
  - Else: cnt[i] <= cnt[i] + 1.
  - Net effect: a change must persist for 3 consecutive ticks. Any glitch lasting fewer than 3 ticks is rejected.
- Change latency: from an in_port change to stable update is between 2*DEBOUNCE_CYCLES+2 and 3*DEBOUNCE_CYCLES+3 clk.
- Register map (word address):
  - 0 DATA: RO, {zero-extend, stable}.
  - 1 MASK: RW, bits [WIDTH-1:0].
  - 2 EDGE: read = edge capture; write 1 to a bit to clear it.
  - 3 RAW: RO, {zero-extend, sync}, for diagnostics.
  - Unused upper bits read 0.
- Write = chipselect & ~write_n. Writes to addresses 0 and 3 are ignored.
- Edge capture: edge[i] <= 1 when chg[i]. Set has priority over a write-1-clear in the same cycle.
- Read: readdata <= mux(address) every clk, independent of chipselect (0 wait states, readLatency 1). A read in the same cycle as a write returns the pre-write value.
- irq: registered, irq <= |(edge & mask). It is asserted 1 clk after the edge/mask update and deasserts 1 clk after the clear/unmask.
- Counters never overflow (2-bit per bit, prescaler bounded).
- Reset mid-debounce discards all pending state, and re-priming follows.

Decomposition:
- Package switch_input_pkg holds:
  - register address constants ADDR_DATA = 0, ADDR_MASK = 1, ADDR_EDGE = 2, ADDR_RAW = 3
  - DB_THRESH = 2
  - AVALON_DW = 32
- Sub-module switch_debounce_bit: synchroniser + 2-bit counter + stable flop + chg pulse for one bit. Inputs: clk, reset_n, tick, primed, raw. It is instantiated WIDTH times via generate.
- Top-level contents: prescaler, primed flag, registers, read mux, irq.

Test Plan:
All tests use DEBOUNCE_CYCLES = 4 unless stated.
1. Reset/prime:
   - Stimulus: in_port = 18'h00005 during reset; release; run 10 clk.
   - Response: readdata = 0 before the first tick. DATA reads 0x5 after priming. EDGE = 0. irq = 0.
2. Glitch reject:
   - Stimulus: primed at 0; pulse in_port[3] high for 8 clk (2 ticks).
   - Response: DATA stays 0x0. EDGE = 0. irq = 0.
3. Accepted change + IRQ:
   - Stimulus: MASK = 0x8; hold in_port[3] = 1.
   - Response: DATA = 0x8 within 10..15 clk. EDGE = 0x8 in the same cycle as stable. irq = 1 exactly 1 clk later.
4. Masking:
   - Stimulus: MASK = 0; toggle in_port[0] and hold.
   - Response: EDGE bit 0 = 1, irq stays 0. Writing MASK = 1 asserts irq 1 clk later.
5. Clear vs set collision:
   - Stimulus: write EDGE = 0x8 in the exact cycle chg[3] fires again.
   - Response: EDGE[3] remains 1 and irq stays 1. A later clear with no event gives EDGE = 0 and irq = 0 1 clk after.
6. Reset mid-debounce:
   - Stimulus: assert reset_n = 0 after 2 mismatch ticks; release.
   - Response: all registers 0. Re-priming adopts the current input with no edge set.

Source files
------------

// File: rtl/switch_input_ctrl_pkg.sv
// Shared constants for the slide-switch input controller: register map,
// debounce threshold and Avalon data width.
package switch_input_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_RAW  = 2'd3;

  // A change is accepted on the tick after the counter has reached this value.
  localparam int DB_THRESH = 2;
  localparam int AVALON_DW = 32;

endpackage

// File: rtl/switch_input_ctrl_if.sv
// Avalon-MM slave bus between the Nios II data master and the switch controller.
interface switch_input_ctrl_if;
  import switch_input_pkg::*;

  logic [1:0]           address;
  logic                 chipselect;
  logic                 write_n;
  logic [AVALON_DW-1:0] writedata;
  logic [AVALON_DW-1:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/switch_debounce_bit.sv
// One switch input: two-flop synchroniser, tick-driven 2-bit persistence
// counter, debounced level and a one-cycle change pulse.
module switch_debounce_bit
  import switch_input_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic primed,
  input  logic raw,
  output logic sync,
  output logic stable,
  output logic chg
);

  logic       meta_q, meta_d;
  logic       sync_q, sync_d;
  logic       stable_q, stable_d;
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    meta_d   = raw;
    sync_d   = meta_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    chg      = 1'b0;
    if (tick) begin
      // First tick after reset adopts the input silently.
      if (!primed) begin
        stable_d = sync_q;
        cnt_d    = '0;
      end else if (sync_q == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == 2'(DB_THRESH)) begin
        stable_d = ~stable_q;
        cnt_d    = '0;
        chg      = 1'b1;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sync   = sync_q;
  assign stable = stable_q;

endmodule

// File: rtl/switch_input_ctrl.sv
// Avalon-MM slide-switch controller: shared debounce prescaler, per-bit
// debouncers, DATA/MASK/EDGE/RAW registers and a maskable level IRQ.
module switch_input_ctrl
  import switch_input_pkg::*;
#(
  parameter int WIDTH           = 18,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  switch_input_ctrl_if.slave    bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  logic [CNT_W-1:0]     pcnt_q, pcnt_d;
  logic                 primed_q, primed_d;
  logic                 tick;
  logic [WIDTH-1:0]     sync, stable, chg;
  logic [WIDTH-1:0]     mask_q, mask_d;
  logic [WIDTH-1:0]     edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0]     clr;
  logic [AVALON_DW-1:0] readdata_q, readdata_d;
  logic                 irq_q, irq_d;
  logic                 wr;
  logic                 unused_wdata;

  assign unused_wdata = ^bus.writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    switch_debounce_bit u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick),
      .primed  (primed_q),
      .raw     (in_port[i]),
      .sync    (sync[i]),
      .stable  (stable[i]),
      .chg     (chg[i])
    );
  end

  always_comb begin
    tick     = (pcnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
    pcnt_d   = tick ? '0 : pcnt_q + CNT_W'(1);
    primed_d = primed_q | tick;

    wr     = bus.chipselect & ~bus.write_n;
    mask_d = mask_q;
    if (wr && bus.address == ADDR_MASK) mask_d = bus.writedata[WIDTH-1:0];

    // A new change wins over a write-1-clear landing in the same cycle.
    clr        = (wr && bus.address == ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;
    edge_cap_d = (edge_cap_q & ~clr) | chg;

    irq_d = |(edge_cap_q & mask_q);

    case (bus.address)
      ADDR_DATA: readdata_d = AVALON_DW'(stable);
      ADDR_MASK: readdata_d = AVALON_DW'(mask_q);
      ADDR_EDGE: readdata_d = AVALON_DW'(edge_cap_q);
      default:   readdata_d = AVALON_DW'(sync);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_q     <= '0;
      primed_q   <= 1'b0;
      mask_q     <= '0;
      edge_cap_q <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      pcnt_q     <= pcnt_d;
      primed_q   <= primed_d;
      mask_q     <= mask_d;
      edge_cap_q <= edge_cap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_switch_input_ctrl.sv
// Bench for switch_input_ctrl with a fast debounce tick (4 clk): directed
// scenarios plus randomized traffic against a behavioural model.
module tb_switch_input_ctrl;
  import switch_input_pkg::*;

  localparam int W  = 18;
  localparam int D  = 4;
  localparam int CW = 3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] in_port;
  logic         irq;
  int           total = 0;
  int           bad = 0;
  int           cyc;

  switch_input_ctrl_if bus ();

  switch_input_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Posedges since reset release; ticks fall on posedges where cyc % D == 0.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;

  // Reference model: a bit flips once its last three tick samples all
  // disagree with the debounced level.
  logic [W-1:0] m_s1, m_s2, m_st, m_h0, m_h1, m_edge, m_mask, m_flips;
  logic [31:0]  m_rd;
  int           m_pcnt;
  logic         m_primed, m_irq, m_tick, m_wr;

  always_comb begin
    m_tick  = (m_pcnt == D - 1);
    m_wr    = bus.chipselect & ~bus.write_n;
    m_flips = (m_tick && m_primed) ? ((m_s2 ^ m_st) & (m_h0 ^ m_st) & (m_h1 ^ m_st)) : '0;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 <= '0; m_s2 <= '0; m_st <= '0; m_h0 <= '0; m_h1 <= '0;
      m_edge <= '0; m_mask <= '0; m_rd <= '0; m_pcnt <= 0;
      m_primed <= 1'b0; m_irq <= 1'b0;
    end else begin
      m_s1   <= in_port;
      m_s2   <= m_s1;
      m_pcnt <= m_tick ? 0 : m_pcnt + 1;
      if (m_tick) begin
        m_primed <= 1'b1;
        m_h0     <= m_s2;
        m_h1     <= m_primed ? m_h0 : m_s2;
        m_st     <= m_primed ? (m_st ^ m_flips) : m_s2;
      end
      if (m_wr && bus.address == 2'd1) m_mask <= bus.writedata[W-1:0];
      m_edge <= (m_edge & ~((m_wr && bus.address == 2'd2) ? bus.writedata[W-1:0] : '0)) | m_flips;
      m_irq  <= |(m_edge & m_mask);
      case (bus.address)
        2'd0:    m_rd <= 32'(m_st);
        2'd1:    m_rd <= 32'(m_mask);
        2'd2:    m_rd <= 32'(m_edge);
        default: m_rd <= 32'(m_s2);
      endcase
    end
  end

  task automatic bus_idle();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
  endtask

  task automatic do_reset(input logic [W-1:0] v);
    @(negedge clk);
    reset_n = 1'b0;
    in_port = v;
    bus_idle();
    bus.address = ADDR_DATA;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
    @(negedge clk);
    bus.address = a;
    @(negedge clk);
    v = bus.readdata;
  endtask

  task automatic align_to_tick();
    for (int k = 0; k < 2 * D && (cyc % D) != 0; k++) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    @(negedge clk);
    reset_n = 1'b0; in_port = 18'h00005; bus_idle(); bus.address = ADDR_DATA;
    repeat (3) @(negedge clk);
    total++; if (bus.readdata !== 32'h0) begin bad++; $display("FAIL reset_readdata: got %h want %h", bus.readdata, 32'h0); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.readdata !== 32'h0) begin bad++; $display("FAIL pre_tick_data: got %h want %h", bus.readdata, 32'h0); end
    repeat (7) @(negedge clk);
    total++; if (bus.readdata !== 32'h5) begin bad++; $display("FAIL primed_data: got %h want %h", bus.readdata, 32'h5); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL primed_irq: got %b want 0", irq); end
    read_reg(ADDR_EDGE, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL primed_edge: got %h want %h", v, 32'h0); end
    read_reg(ADDR_RAW, v);
    total++; if (v !== 32'h5) begin bad++; $display("FAIL raw_read: got %h want %h", v, 32'h5); end
    read_reg(ADDR_MASK, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_mask: got %h want %h", v, 32'h0); end
  endtask

  task automatic test_glitch();
    logic [31:0] v;
    do_reset('0);
    repeat (10) @(negedge clk);
    in_port[3] = 1'b1;
    repeat (8) @(negedge clk);
    in_port[3] = 1'b0;
    repeat (16) @(negedge clk);
    read_reg(ADDR_DATA, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL glitch_data: got %h want %h", v, 32'h0); end
    read_reg(ADDR_EDGE, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL glitch_edge: got %h want %h", v, 32'h0); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL glitch_irq: got %b want 0", irq); end
  endtask

  task automatic test_accept();
    logic [31:0] v;
    int          lat;
    logic        irq_before;
    lat = -1;
    irq_before = 1'b1;
    bus_write(ADDR_MASK, 32'h8);
    bus.address = ADDR_DATA;
    in_port[3]  = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (bus.readdata === 32'h8) begin lat = n; break; end
      irq_before = irq;
    end
    total++; if (lat < 10 || lat > 15) begin bad++; $display("FAIL accept_latency: got %0d want 10..15", lat); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL accept_irq: got %b want 1", irq); end
    total++; if (irq_before !== 1'b0) begin bad++; $display("FAIL accept_irq_early: got %b want 0", irq_before); end
    read_reg(ADDR_EDGE, v);
    total++; if (v !== 32'h8) begin bad++; $display("FAIL accept_edge: got %h want %h", v, 32'h8); end
  endtask

  task automatic test_mask();
    logic [31:0] v;
    bus_write(ADDR_MASK, 32'h0);
    bus_write(ADDR_EDGE, 32'h3FFFF);
    in_port[0] = 1'b1;
    repeat (20) @(negedge clk);
    read_reg(ADDR_EDGE, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL mask_edge: got %h want %h", v, 32'h1); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL masked_irq: got %b want 0", irq); end
    read_reg(ADDR_DATA, v);
    total++; if (v !== 32'h9) begin bad++; $display("FAIL mask_data: got %h want %h", v, 32'h9); end
    bus_write(ADDR_MASK, 32'h1);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL unmask_irq_same: got %b want 0", irq); end
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL unmask_irq_next: got %b want 1", irq); end
  endtask

  task automatic test_collision();
    logic [31:0] v;
    bus_write(ADDR_MASK, 32'h8);
    bus_write(ADDR_EDGE, 32'h1);
    in_port[3] = 1'b0;
    repeat (20) @(negedge clk);
    read_reg(ADDR_EDGE, v);
    total++; if (v !== 32'h8) begin bad++; $display("FAIL coll_pre_edge: got %h want %h", v, 32'h8); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL coll_pre_irq: got %b want 1", irq); end
    align_to_tick();
    in_port[3] = 1'b1;
    // Third mismatching tick lands 12 posedges later; put the clear on it.
    repeat (11) @(negedge clk);
    bus.address = ADDR_EDGE; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = 32'h8;
    @(negedge clk);
    bus_idle();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL coll_irq0: got %b want 1", irq); end
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL coll_irq1: got %b want 1", irq); end
    total++; if (bus.readdata !== 32'h8) begin bad++; $display("FAIL coll_edge: got %h want %h", bus.readdata, 32'h8); end
    read_reg(ADDR_DATA, v);
    total++; if (v !== 32'h9) begin bad++; $display("FAIL coll_data: got %h want %h", v, 32'h9); end
    bus_write(ADDR_EDGE, 32'h8);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL clear_irq_same: got %b want 1", irq); end
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL clear_irq_next: got %b want 0", irq); end
    read_reg(ADDR_EDGE, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL clear_edge: got %h want %h", v, 32'h0); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    align_to_tick();
    in_port = 18'h00006;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++; if (bus.readdata !== 32'h0) begin bad++; $display("FAIL mid_reset_readdata: got %h want %h", bus.readdata, 32'h0); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL mid_reset_irq: got %b want 0", irq); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    read_reg(ADDR_MASK, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL mid_reset_mask: got %h want %h", v, 32'h0); end
    repeat (10) @(negedge clk);
    read_reg(ADDR_DATA, v);
    total++; if (v !== 32'h6) begin bad++; $display("FAIL reprime_data: got %h want %h", v, 32'h6); end
    read_reg(ADDR_EDGE, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL reprime_edge: got %h want %h", v, 32'h0); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reprime_irq: got %b want 0", irq); end
  endtask

  task automatic test_random();
    do_reset(W'($urandom));
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      total++; if (bus.readdata !== m_rd) begin bad++; $display("FAIL rand_readdata[%0d]: got %h want %h", n, bus.readdata, m_rd); end
      total++; if (irq !== m_irq) begin bad++; $display("FAIL rand_irq[%0d]: got %b want %b", n, irq, m_irq); end
      if ($urandom_range(0, 5) == 0) in_port[$urandom_range(0, W - 1)] ^= 1'b1;
      bus.address    = 2'($urandom_range(0, 3));
      bus.chipselect = ($urandom_range(0, 3) != 0);
      bus.write_n    = ($urandom_range(0, 7) != 0);
      bus.writedata  = $urandom;
    end
    bus_idle();
  endtask

  initial begin
    reset_n = 1'b0;
    in_port = '0;
    bus.address = ADDR_DATA;
    bus_idle();
    test_reset();
    test_glitch();
    test_accept();
    test_mask();
    test_collision();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
